imem_boot_loader: RTL and testbench

- Upstream of the single-cycle MIPS core: streams a program image over a byte-wide valid/ready link and writes it, word by word, into the core's instruction memory.
- Holds the core in hold (PC pinned to 0) until the image is fully written, then releases it.
- Replaces bench-side $readmemb preloading; the same image path serves synthesis and simulation.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_boot_loader_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Latency: n/a (types, constants and a combinational packing function).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    WORD,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Big-endian word assembly: b0 arrived first and lands in bits [31:24].
  function automatic logic [31:0] pack_be(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Collects four stream bytes into one big-endian 32-bit instruction word.
// Latency: word valid the cycle after the 4th shift; full flags that cycle.
// Backpressure: none internally; shifts only when the parent enables it.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  idx,
  output logic        full,
  output logic [31:0] word
);

  logic [7:0] bytes_q [BYTES_PER_WORD];

  // Shift bytes toward slot 0 so the oldest byte ends up as the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 2'd0;
      full <= 1'b0;
      for (int i = 0; i < BYTES_PER_WORD; i++) bytes_q[i] <= 8'h00;
    end else if (clr) begin
      idx  <= 2'd0;
      full <= 1'b0;
    end else if (shift_en) begin
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) bytes_q[i] <= bytes_q[i+1];
      bytes_q[BYTES_PER_WORD-1] <= byte_in;
      idx <= idx + 2'd1;
      if (idx == 2'd3) full <= 1'b1;
    end
  end

  assign word = pack_be(bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into imem and holds the core until done.
// Latency: 2 header transfers, then 5 cycles minimum per word (4 bytes + 1 write).
// Backpressure: in_ready low outside load states and during WRITE; in_valid gaps stall.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  state_t                 state, state_nxt;
  logic [8*HDR_BYTES-1:0] n_words;
  logic [8*HDR_BYTES-1:0] hdr_n;
  logic                   xfer;
  logic                   start_load;
  logic                   last_word;
  logic                   pk_clr;
  logic                   pk_shift;
  logic                   pk_full;
  logic [1:0]             pk_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  assign xfer       = in_valid && in_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign hdr_n      = {n_words[15:8], in_data};
  assign last_word  = (words_loaded + 16'd1) == n_words;
  assign pk_shift   = xfer && (state == WORD);

  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .shift_en (pk_shift),
    .byte_in  (in_data),
    .idx      (pk_idx),
    .full     (pk_full),
    .word     (imem_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state outputs; a new load may start from IDLE, DONE or ERR.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_hold  = 1'b1;
    imem_we   = 1'b0;
    pk_clr    = start_load;
    if (start_load) state_nxt = HDR_HI;
    case (state)
      IDLE: ;
      HDR_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (hdr_n == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          else if (hdr_n > (8*HDR_BYTES)'(IMEM_WORDS)) state_nxt = ERR;
          else                                           state_nxt = WORD;
        end
      end
      WORD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && pk_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        imem_we = pk_full;
        pk_clr  = 1'b1;
        if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = DONE;
`endif
        else
          state_nxt = WORD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR: begin
        error = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header latch, write address and word count; cleared when a load starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words      <= '0;
      imem_addr    <= '0;
      words_loaded <= 16'd0;
    end else begin
      if (start_load) begin
        imem_addr    <= '0;
        words_loaded <= 16'd0;
      end
      if (state == HDR_HI && xfer) n_words[15:8] <= in_data;
      if (state == HDR_LO && xfer) n_words[7:0]  <= in_data;
      if (state == WRITE) begin
        imem_addr    <= imem_addr + ADDR_W'(BYTES_PER_WORD);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over every header and body byte; the check byte itself is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     csum <= 8'h00;
    else if (start_load)            csum <= 8'h00;
    else if (xfer && state != CSUM) csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: swap program, stalls, bounds, reset, checksum.
// Latency: checks cycle counts from the start edge to done/error.
// Backpressure: stream driver honours in_ready and optionally gaps in_valid.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  logic [7:0]  stim [$];
  logic [7:0]  wa [$];
  logic [31:0] wd [$];
  logic [31:0] exp_w [3];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  // XOR of 00 03 8C 08 00 00 8C 09 00 04 AC 09 00 00
  localparam logic [7:0] CSUM3 = 8'hA3;

  imem_boot_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t_start = cyc;
  endtask

  // Present stim bytes; a byte advances only when in_valid && in_ready at the edge.
  task automatic push_stream(input bit toggle, output int sent);
    int  i = 0;
    int  n = 0;
    bit  phase = 1'b1;
    bit  acc;
    while (i < stim.size() && n < 2000) begin
      @(negedge clk);
      in_valid = toggle ? phase : 1'b1;
      in_data  = stim[i];
      phase    = ~phase;
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      n++;
    end
    #1 in_valid = 1'b0;
    sent = i;
  endtask

  task automatic wait_end(input int max, output int elapsed);
    int k = 0;
    while (!(done || error) && k < max) begin
      @(negedge clk);
      k++;
    end
    elapsed = cyc - t_start;
  endtask

  task automatic load_image3(input logic [7:0] csum_byte);
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h03);
    for (int w = 0; w < 3; w++) begin
      logic [31:0] v;
      v = exp_w[w];
      stim.push_back(v[31:24]);
      stim.push_back(v[23:16]);
      stim.push_back(v[15:8]);
      stim.push_back(v[7:0]);
    end
    if (CS != 0) stim.push_back(csum_byte);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcnt"}, wa.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        chk({tag, "_waddr"}, wa[i], 32'(4 * i));
        chk({tag, "_wdata"}, wd[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    int sent;
    int el;
    exp_w[0] = 32'h8C080000;
    exp_w[1] = 32'h8C090004;
    exp_w[2] = 32'hAC090000;

    // Reset values
    #12;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    rst_n = 1'b1;

    // in_valid while idle is ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_error", error, 0);
    in_valid = 1'b0;

    // Swap program, continuous valid
    wa.delete(); wd.delete();
    load_image3(CSUM3);
    start_load();
    chk("t1_busy", busy, 1);
    push_stream(1'b0, sent);
    chk("t1_sent", sent, stim.size());
    wait_end(100, el);
    chk("t1_latency", el, 17 + CS);
    chk("t1_done", done, 1);
    chk("t1_cpu_hold", cpu_hold, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_words", words_loaded, 3);
    check_writes("t1");

    // Same image with gapped valid; restart from DONE
    wa.delete(); wd.delete();
    start_load();
    chk("t2_done_clr", done, 0);
    chk("t2_hold", cpu_hold, 1);
    chk("t2_words_clr", words_loaded, 0);
    chk("t2_addr_clr", imem_addr, 0);
    push_stream(1'b1, sent);
    chk("t2_sent", sent, stim.size());
    wait_end(100, el);
    chk("t2_done", done, 1);
    chk("t2_words", words_loaded, 3);
    check_writes("t2");

    // Oversized header N=65
    wa.delete(); wd.delete();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h41);
    start_load();
    push_stream(1'b0, sent);
    wait_end(100, el);
    chk("t3_latency", el, 2);
    chk("t3_error", error, 1);
    chk("t3_done", done, 0);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t3_no_we", wa.size(), 0);
    load_image3(CSUM3);
    start_load();
    chk("t3_err_clr", error, 0);
    push_stream(1'b0, sent);
    wait_end(100, el);
    chk("t3_reload_done", done, 1);
    check_writes("t3");

    // Empty image N=0
    wa.delete(); wd.delete();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    if (CS != 0) stim.push_back(8'h00);
    start_load();
    push_stream(1'b0, sent);
    wait_end(100, el);
    chk("t4_latency", el, 2 + CS);
    chk("t4_done", done, 1);
    chk("t4_words", words_loaded, 0);
    repeat (2) @(negedge clk);
    chk("t4_no_we", wa.size(), 0);

    // Reset after 6 body bytes
    wa.delete(); wd.delete();
    load_image3(CSUM3);
    while (stim.size() > 8) void'(stim.pop_back());
    start_load();
    push_stream(1'b0, sent);
    chk("t5_words_mid", words_loaded, 1);
    chk("t5_addr_mid", imem_addr, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_hold", cpu_hold, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_addr", imem_addr, 0);
    chk("t5_wdata", imem_wdata, 0);
    chk("t5_words", words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    load_image3(CSUM3);
    start_load();
    push_stream(1'b0, sent);
    wait_end(100, el);
    chk("t5_reload_done", done, 1);
    chk("t5_reload_words", words_loaded, 3);
    check_writes("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum byte
    wa.delete(); wd.delete();
    load_image3(CSUM3 ^ 8'h01);
    start_load();
    push_stream(1'b0, sent);
    wait_end(100, el);
    chk("t6_latency", el, 18);
    chk("t6_error", error, 1);
    chk("t6_done", done, 0);
    chk("t6_hold", cpu_hold, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
